conv3x3_stream: RTL and testbench
=================================

# conv3x3_stream

Streaming 3x3 valid-mode convolution stage that sits directly upstream of `max_pool` in the CNN1 datapath. It consumes a raster-order 8-bit pixel stream of one 28x28 image with a single-channel kernel. It emits the 26x26 feature map as signed `DATA_WIDTH` samples in raster order with a `valid_out` strobe. The output stream format matches what `max_pool` expects on `data_in`/`valid_in`.

## Interface
- `PIXEL_WIDTH`, 8: unsigned input pixel width.
- `WEIGHT_WIDTH`, 8: signed kernel weight width.
- `BIAS_WIDTH`, 16: signed bias width.
- `DATA_WIDTH`, 20: signed output width.
- `IMG_WIDTH`, 28: input columns.
- `IMG_HEIGHT`, 28: input rows.
- `RELU_EN`, 1: when 1, negative results are clamped to 0.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `enable`  in  1: when low, input beats are ignored.
- `weights`  in  9*WEIGHT_WIDTH: signed kernel, raster order; w[0] is the top-left tap and occupies bits [7:0]. Must be held stable for the whole frame.
- `bias`  in  BIAS_WIDTH: signed bias, held stable for the whole frame.
- `data_in`  in  PIXEL_WIDTH: pixel, interpreted as unsigned.
- `valid_in`  in  1: beat qualifier.
- `data_out`  out  DATA_WIDTH: signed convolution result.
- `valid_out`  out  1: one-cycle strobe per output sample.
- `frame_done`  out  1: one-cycle pulse, asserted together with the last `valid_out` of each frame.

## Operation
- A beat is accepted when `valid_in && enable` at a rising edge. There is no backpressure.
- Column counter `col` (0..IMG_WIDTH-1) and row counter `row` (0..IMG_HEIGHT-1) advance only on accepted beats.
  - `col` wraps to 0 and increments `row`.
  - After the final beat (`row`=IMG_HEIGHT-1, `col`=IMG_WIDTH-1), both counters wrap to 0. The next accepted beat is pixel (0,0) of the next frame.
- Two line buffers of depth IMG_WIDTH hold the previous two rows. A 3x3 window register shifts left on each accepted beat. The new column of the window is {line2 out, line1 out, data_in}.
- A window is valid when the accepted beat has `row`>=2 and `col`>=2. This yields exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) = 676 outputs per frame.
- Previous-frame line-buffer contents never reach the output, because rows 0-1 of each frame are suppressed.
- Arithmetic:
  - Each product is the pixel zero-extended to 9 bits times the signed 8-bit weight, giving a 17-bit signed product.
  - The nine products and the sign-extended bias are summed at DATA_WIDTH.
  - Worst-case magnitude is 9*255*128 + 32768 = 326528, which is below 2^19. The sum is therefore exact, with no saturation or rounding.
- ReLU is applied after the bias when `RELU_EN`=1.
- `enable` low: no beats are accepted and the counters hold. Results already in the pipeline still drain and emerge normally.
- `rst`:
  - Clears the counters, the window, the pipeline valid tags, `valid_out`, `frame_done` and `data_out` to 0 at the next edge.
  - In-flight results are discarded.
  - Line-buffer RAM contents need not be cleared.

## Timing
- Pipeline stages:
  - Edge k: the beat is accepted and the window is updated.
  - Edge k+1: the nine products are registered.
  - Edge k+2: sum + bias + ReLU is registered to `data_out`, and `valid_out`=1 for one cycle.
- Latency is 2 cycles from the accepting edge to `valid_out`.
- Throughput is one output per accepted beat. Back-to-back outputs are allowed.
- `valid_out` carries the valid tag only. Bubbles in `valid_in` produce matching gaps in `valid_out`.
- `frame_done` is tagged at the beat with `row`=IMG_HEIGHT-1, `col`=IMG_WIDTH-1 and travels through the same 2-stage pipeline.
- Reset values of all outputs: `data_out`=0, `valid_out`=0, `frame_done`=0.
- `data_out` holds its last value while `valid_out` is low.

## Structure
- Shared include `cnn_params.vh` holds:
  - the image dimensions (28, 26, 13);
  - `PIXEL_WIDTH`, `WEIGHT_WIDTH`, `BIAS_WIDTH` and `DATA_WIDTH` defaults, so that `max_pool` and this block agree on widths.
- One sub-module, `line_buffer`:
  - parameters: `DEPTH` and `WIDTH`;
  - behaviour: a shift/circular RAM that shifts only when enabled;
  - instantiated twice, chained.
- The window, multipliers, adder tree and control counters live in the top module.

## Test plan
- All pixels = 1, all weights = 1, bias = 0 → exactly 676 outputs, all equal to 9. `frame_done` pulses once, on output #676.
- Identity kernel (w[4]=1, others 0), pixel(r,c) = (r*28+c) mod 256, bias = 0 → output i at (r,c) equals pixel(r+1,c+1), in raster order.
- All pixels = 255, all weights = -1, bias = 0:
  - `RELU_EN`=1 → all outputs are 0;
  - `RELU_EN`=0 → all outputs are -2295.
- Extremes: pixels = 255, weights = 127, bias = 32767 → all outputs are 324232, with no overflow. Repeat with weights = -128, bias = -32768, `RELU_EN`=0 → -326528.
- Random `valid_in` bubbles plus `enable` toggling during the identity-kernel frame → the same 676 values as the gapless run. Each output lands exactly 2 cycles after its accepting beat.
- Assert `rst` for 1 cycle after 300 accepted beats, then stream two full frames back-to-back:
  - `valid_out` is 0 from the cycle after reset;
  - there are no outputs from the partial frame;
  - exactly 2×676 correct outputs and 2 `frame_done` pulses follow.

Source files
------------

// File: rtl/conv3x3_stream_pkg.sv
// conv3x3_stream_pkg
//   Shared CNN1 datapath constants and small helpers. Both this block and the
//   downstream max_pool take their image dimensions and sample widths from
//   here, so the two stages always agree on the stream format.
//   Contents:
//     CNN_IMG_WIDTH / CNN_IMG_HEIGHT  input image size (28 x 28)
//     CNN_CONV_OUT                    valid-mode conv output size (26)
//     CNN_POOL_OUT                    2x2 pooled output size (13)
//     CNN_*_WIDTH                     default pixel/weight/bias/data widths
//     tag_t                           per-beat pipeline tag (valid + last)
//     cnt_width()                     counter width for a 0..n-1 range
package conv3x3_stream_pkg;

  localparam int CNN_IMG_WIDTH    = 28;
  localparam int CNN_IMG_HEIGHT   = 28;
  localparam int CNN_CONV_OUT     = 26;
  localparam int CNN_POOL_OUT     = 13;

  localparam int CNN_PIXEL_WIDTH  = 8;
  localparam int CNN_WEIGHT_WIDTH = 8;
  localparam int CNN_BIAS_WIDTH   = 16;
  localparam int CNN_DATA_WIDTH   = 20;

  localparam int NUM_TAPS         = 9;

  // Tag carried alongside each beat through the arithmetic pipeline.
  typedef struct packed {
    logic valid;  // beat completed a full 3x3 window
    logic last;   // beat was the final pixel of the frame
  } tag_t;

  // Bits needed to count 0..n-1 (at least 1).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/line_buffer.sv
// line_buffer
//   One image row of delay implemented as a circular RAM. On every enabled
//   cycle the word written DEPTH enabled cycles ago is presented on dout
//   (read-before-write at the same address) and din replaces it. When en is
//   low nothing moves, so the delay is counted in accepted beats, not cycles.
//   Ports:
//     clk   clock, rising edge
//     rst   synchronous active-high; resets only the pointer, not the RAM
//     en    advance the buffer by one word
//     din   word entering the buffer
//     dout  word that entered DEPTH enabled cycles ago
module line_buffer
  import conv3x3_stream_pkg::*;
#(
  parameter int DEPTH = CNN_IMG_WIDTH,
  parameter int WIDTH = CNN_PIXEL_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int PTR_W = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] ptr;

  assign dout = mem[ptr];

  // RAM contents are don't-care after reset: the first two rows of every
  // frame never reach the output, so stale words are never observed.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (en) begin
      if (ptr == PTR_W'(DEPTH - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv3x3_stream.sv
// conv3x3_stream
//   Streaming 3x3 valid-mode convolution over one raster-order image. Feeds
//   max_pool directly with signed DATA_WIDTH samples in raster order.
//   Stream semantics (both sides): a beat exists on an edge where its
//   qualifier is high; there is no ready/backpressure. Input beats count only
//   when valid_in && enable. valid_out is a one-cycle strobe per result and
//   data_out holds its last value while valid_out is low.
//   Ports:
//     clk, rst     clock (rising edge), synchronous active-high reset
//     enable       gates input acceptance; pipeline keeps draining when low
//     weights      9 signed taps, raster order, tap 0 (top-left) in LSBs
//     bias         signed bias added after the nine products
//     data_in      unsigned pixel
//     valid_in     input beat qualifier
//     data_out     signed convolution result (ReLU'd when RELU_EN != 0)
//     valid_out    result strobe, 2 cycles after the accepting edge
//     frame_done   pulses with the last valid_out of each frame
module conv3x3_stream
  import conv3x3_stream_pkg::*;
#(
  parameter int PIXEL_WIDTH  = CNN_PIXEL_WIDTH,
  parameter int WEIGHT_WIDTH = CNN_WEIGHT_WIDTH,
  parameter int BIAS_WIDTH   = CNN_BIAS_WIDTH,
  parameter int DATA_WIDTH   = CNN_DATA_WIDTH,
  parameter int IMG_WIDTH    = CNN_IMG_WIDTH,
  parameter int IMG_HEIGHT   = CNN_IMG_HEIGHT,
  parameter int RELU_EN      = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic [NUM_TAPS*WEIGHT_WIDTH-1:0] weights,
  input  logic [BIAS_WIDTH-1:0]            bias,
  input  logic [PIXEL_WIDTH-1:0]           data_in,
  input  logic                             valid_in,
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic                             valid_out,
  output logic                             frame_done
);

  localparam int COL_W  = cnt_width(IMG_WIDTH);
  localparam int ROW_W  = cnt_width(IMG_HEIGHT);
  // Pixel is zero-extended by one bit so it multiplies as a signed value.
  localparam int PROD_W = PIXEL_WIDTH + 1 + WEIGHT_WIDTH;

  // ---------------------------------------------------------------------
  // Input acceptance and raster position
  // ---------------------------------------------------------------------
  logic             accept;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             col_last;
  logic             row_last;

  assign accept   = valid_in && enable;
  assign col_last = (col == COL_W'(IMG_WIDTH - 1));
  assign row_last = (row == ROW_W'(IMG_HEIGHT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Row history: lb1 yields the pixel one row above data_in, lb2 two rows.
  // ---------------------------------------------------------------------
  logic [PIXEL_WIDTH-1:0] line1_out;
  logic [PIXEL_WIDTH-1:0] line2_out;

  line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PIXEL_WIDTH)
  ) u_line1 (
    .clk  (clk),
    .rst  (rst),
    .en   (accept),
    .din  (data_in),
    .dout (line1_out)
  );

  line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PIXEL_WIDTH)
  ) u_line2 (
    .clk  (clk),
    .rst  (rst),
    .en   (accept),
    .din  (line1_out),
    .dout (line2_out)
  );

  // ---------------------------------------------------------------------
  // Stage 0: 3x3 window. win[r][c] with r=0 the oldest row and c=0 the
  // oldest column, so win[0][0] lines up with tap 0 (top-left).
  // ---------------------------------------------------------------------
  logic [PIXEL_WIDTH-1:0] win [3][3];
  tag_t                   tag0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= line2_out;
      win[1][2] <= line1_out;
      win[2][2] <= data_in;
    end
  end

  // A window is complete only once two full rows and two columns of the
  // current frame are in; this also hides previous-frame line contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag0 <= '0;
    end else begin
      tag0.valid <= accept && (row >= ROW_W'(2)) && (col >= COL_W'(2));
      tag0.last  <= accept && row_last && col_last;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: nine registered products
  // ---------------------------------------------------------------------
  logic signed [PROD_W-1:0] prod_c [NUM_TAPS];
  logic signed [PROD_W-1:0] prod_q [NUM_TAPS];
  tag_t                     tag1;

  always_comb begin
    for (int i = 0; i < NUM_TAPS; i++) begin
      prod_c[i] = $signed({1'b0, win[i / 3][i % 3]})
                * $signed(weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        prod_q[i] <= '0;
      end
      tag1 <= '0;
    end else begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        prod_q[i] <= prod_c[i];
      end
      tag1 <= tag0;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: adder tree + bias + optional ReLU. DATA_WIDTH holds the
  // worst-case sum exactly, so no saturation is needed.
  // ---------------------------------------------------------------------
  logic signed [DATA_WIDTH-1:0] sum_c;
  logic signed [DATA_WIDTH-1:0] result_c;

  always_comb begin
    sum_c = DATA_WIDTH'($signed(bias));
    for (int i = 0; i < NUM_TAPS; i++) begin
      sum_c = sum_c + DATA_WIDTH'(prod_q[i]);
    end
    result_c = sum_c;
    if ((RELU_EN != 0) && sum_c[DATA_WIDTH-1]) begin
      result_c = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= tag1.valid;
      frame_done <= tag1.valid && tag1.last;
      if (tag1.valid) begin
        data_out <= result_c;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_stream.sv
// tb_conv3x3_stream
//   Two instances share the input stream: dut_r with ReLU, dut_n without.
//   Frame-level vectors come from a table of hand-computed expectations;
//   the reset-during-frame case is a hand-written sequence.
module tb_conv3x3_stream;
  import conv3x3_stream_pkg::*;

  localparam int W    = 20;
  localparam int NOUT = 676;
  localparam int NPIX = 784;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          valid_in;
  logic [7:0]    data_in;
  logic [71:0]   weights;
  logic [15:0]   bias;
  logic [W-1:0]  d_r, d_n;
  logic          vo_r, vo_n, fd_r, fd_n;

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  conv3x3_stream #(.RELU_EN(1)) dut_r (
    .clk(clk), .rst(rst), .enable(enable), .weights(weights), .bias(bias),
    .data_in(data_in), .valid_in(valid_in),
    .data_out(d_r), .valid_out(vo_r), .frame_done(fd_r)
  );

  conv3x3_stream #(.RELU_EN(0)) dut_n (
    .clk(clk), .rst(rst), .enable(enable), .weights(weights), .bias(bias),
    .data_in(data_in), .valid_in(valid_in),
    .data_out(d_n), .valid_out(vo_n), .frame_done(fd_n)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [W-1:0] data;
    int           cyc;
    bit           last;
  } exp_t;

  exp_t exp_r_q[$];
  exp_t exp_n_q[$];

  int errors = 0;
  int checks = 0;
  int out_r = 0, out_n = 0, fdc_r = 0, fdc_n = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (vo_r) begin
      out_r++;
      if (fd_r) fdc_r++;
      checks++;
      if (exp_r_q.size() == 0) begin
        errors++;
        $display("FAIL relu_extra_output: got data %0d, expected no output", sx(d_r));
      end else begin
        e = exp_r_q.pop_front();
        check("relu_data", sx(d_r), sx(e.data));
        check("relu_latency_edge", edge_n, e.cyc);
        check("relu_frame_done", int'(fd_r), int'(e.last));
      end
    end else begin
      check("relu_frame_done_idle", int'(fd_r), 0);
    end
    if (vo_n) begin
      out_n++;
      if (fd_n) fdc_n++;
      checks++;
      if (exp_n_q.size() == 0) begin
        errors++;
        $display("FAIL norelu_extra_output: got data %0d, expected no output", sx(d_n));
      end else begin
        e = exp_n_q.pop_front();
        check("norelu_data", sx(d_n), sx(e.data));
        check("norelu_latency_edge", edge_n, e.cyc);
        check("norelu_frame_done", int'(fd_n), int'(e.last));
      end
    end else begin
      check("norelu_frame_done_idle", int'(fd_n), 0);
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    string        name;
    bit           ramp;    // pixel(r,c) = (r*28+c) mod 256, else constant pix
    logic [7:0]   pix;
    bit           ident;   // identity kernel, else all taps = wv
    logic [7:0]   wv;
    logic [15:0]  bias;
    logic [W-1:0] exp_r;   // constant expectations (unused when ident)
    logic [W-1:0] exp_n;
    bit           bub;     // random valid_in / enable bubbles
  } vec_t;

  vec_t tab[6];

  function automatic logic [7:0] ramp_pix(input int r, input int c);
    return 8'((r * 28 + c) % 256);
  endfunction

  // ---------------- driver ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in = 1'b0;
      enable   = 1'b1;
    end
  endtask

  task automatic send(input int ti, input int r, input int c);
    exp_t er, en;
    while (tab[ti].bub && ($urandom_range(0, 2) == 0)) begin
      @(negedge clk);
      data_in = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0) begin
        valid_in = 1'b0;
        enable   = 1'($urandom_range(0, 1));
      end else begin
        valid_in = 1'b1;
        enable   = 1'b0;
      end
    end
    @(negedge clk);
    data_in  = tab[ti].ramp ? ramp_pix(r, c) : tab[ti].pix;
    valid_in = 1'b1;
    enable   = 1'b1;
    if (r >= 2 && c >= 2) begin
      // accepted on edge edge_n+1, result visible after edge edge_n+3
      er.cyc  = edge_n + 3;
      er.last = (r == 27 && c == 27);
      en      = er;
      if (tab[ti].ident) begin
        er.data = W'(ramp_pix(r - 1, c - 1));
        en.data = er.data;
      end else begin
        er.data = tab[ti].exp_r;
        en.data = tab[ti].exp_n;
      end
      exp_r_q.push_back(er);
      exp_n_q.push_back(en);
    end
  endtask

  task automatic run_beats(input int ti, input int nbeats);
    for (int k = 0; k < nbeats; k++) begin
      send(ti, (k / 28) % 28, k % 28);
    end
  endtask

  task automatic load_vec(input int ti);
    weights = tab[ti].ident ? (72'd1 << 32) : {9{tab[ti].wv}};
    bias    = tab[ti].bias;
  endtask

  task automatic clear_counts();
    out_r = 0; out_n = 0; fdc_r = 0; fdc_n = 0;
  endtask

  task automatic check_counts(input string tag, input int nout, input int nfd);
    check({tag, "_count_relu"}, out_r, nout);
    check({tag, "_count_norelu"}, out_n, nout);
    check({tag, "_frame_done_relu"}, fdc_r, nfd);
    check({tag, "_frame_done_norelu"}, fdc_n, nfd);
    check({tag, "_leftover_relu"}, exp_r_q.size(), 0);
    check({tag, "_leftover_norelu"}, exp_n_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data_relu"}, sx(d_r), 0);
    check({tag, "_valid_relu"}, int'(vo_r), 0);
    check({tag, "_fd_relu"}, int'(fd_r), 0);
    check({tag, "_data_norelu"}, sx(d_n), 0);
    check({tag, "_valid_norelu"}, int'(vo_n), 0);
    check({tag, "_fd_norelu"}, int'(fd_n), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int rst_edge;

    tab[0] = '{"ones",        1'b0, 8'd1,   1'b0, 8'sd1,    16'sd0,
               W'(9),       W'(9),       1'b0};
    tab[1] = '{"identity",    1'b1, 8'd0,   1'b1, 8'sd0,    16'sd0,
               W'(0),       W'(0),       1'b0};
    tab[2] = '{"neg_ones",    1'b0, 8'd255, 1'b0, -8'sd1,   16'sd0,
               W'(0),       W'(-2295),   1'b0};
    tab[3] = '{"max_pos",     1'b0, 8'd255, 1'b0, 8'sd127,  16'sd32767,
               W'(324232),  W'(324232),  1'b0};
    tab[4] = '{"max_neg",     1'b0, 8'd255, 1'b0, -8'sd128, -16'sd32768,
               W'(0),       W'(-326528), 1'b0};
    tab[5] = '{"identity_bub",1'b1, 8'd0,   1'b1, 8'sd0,    16'sd0,
               W'(0),       W'(0),       1'b1};

    rst      = 1'b1;
    enable   = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'd0;
    weights  = '0;
    bias     = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int ti = 0; ti < 6; ti++) begin
      load_vec(ti);
      clear_counts();
      run_beats(ti, NPIX);
      idle(5);
      check_counts(tab[ti].name, NOUT, 1);
    end

    // Reset in the middle of a frame, then two frames back-to-back.
    load_vec(1);
    clear_counts();
    run_beats(1, 300);
    @(negedge clk);
    valid_in = 1'b0;
    rst      = 1'b1;
    rst_edge = edge_n + 1;
    // results that would have emerged on or after the reset edge are lost
    while (exp_r_q.size() > 0 && exp_r_q[$].cyc >= rst_edge) void'(exp_r_q.pop_back());
    while (exp_n_q.size() > 0 && exp_n_q[$].cyc >= rst_edge) void'(exp_n_q.pop_back());
    @(negedge clk);
    check("midrst_valid_relu", int'(vo_r), 0);
    check("midrst_valid_norelu", int'(vo_n), 0);
    check("midrst_fd_relu", int'(fd_r), 0);
    check("midrst_data_relu", sx(d_r), 0);
    rst = 1'b0;
    clear_counts();
    run_beats(1, 2 * NPIX);
    idle(5);
    check_counts("after_reset", 2 * NOUT, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    checks++;
    $display("FAIL timeout: simulation did not complete within time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
